// File: rtl/sensor_ultrasonico_distancia_if.sv
// Sensor-side bundle of the ultrasonic ranger: control/echo inputs and the
// trigger/distance outputs that feed the servo mapping ROM.
interface sensor_ultrasonico_distancia_if;
    logic       en;
    logic       echo;
    logic       trig;
    logic [8:0] distancia;
    logic       dist_valida;
    logic       sin_eco;

    modport master (
        output en,
        output echo,
        input  trig,
        input  distancia,
        input  dist_valida,
        input  sin_eco
    );

    modport slave (
        input  en,
        input  echo,
        output trig,
        output distancia,
        output dist_valida,
        output sin_eco
    );
endinterface

// File: rtl/sensor_ultrasonico_distancia.sv
// HC-SR04-style ranger front end: trigger pulse, echo timing, and echo width
// quantised to distance units with a prescaler and a saturating unit counter.
module sensor_ultrasonico_distancia #(
    parameter int TRIG_CYCLES  = 1000,
    parameter int CYC_PER_UNIT = 11600,
    parameter int DIST_MAX     = 10,
    parameter int ECHO_TIMEOUT = 3800000,
    parameter int PAUSA        = 2000000
) (
    input  logic                            clk,
    input  logic                            reset,
    sensor_ultrasonico_distancia_if.slave   bus
);

    localparam int CNT_MAX0 = (PAUSA > TRIG_CYCLES) ? PAUSA : TRIG_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > ECHO_TIMEOUT) ? CNT_MAX0 : ECHO_TIMEOUT;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PRE_W    = (CYC_PER_UNIT > 1) ? $clog2(CYC_PER_UNIT) : 1;
    localparam int UNIT_W   = (DIST_MAX > 0) ? $clog2(DIST_MAX + 1) : 1;

    // The rising-edge cycle already has echo_s high, so it is counted here.
    localparam logic [PRE_W-1:0]  PRE_FIRST  = (CYC_PER_UNIT > 1) ? PRE_W'(1) : '0;
    localparam logic [UNIT_W-1:0] UNIT_FIRST = (CYC_PER_UNIT == 1 && DIST_MAX > 0) ? UNIT_W'(1) : '0;

    typedef enum logic [2:0] {
        ESPERA,
        DISPARO,
        ESPERA_ECO,
        MEDIR,
        FIN
    } state_t;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [PRE_W-1:0]    r_pre, w_pre;
    logic [UNIT_W-1:0]   r_unit, w_unit;
    logic                r_trig, w_trig;
    logic [8:0]          r_dist, w_dist;
    logic                r_valida, w_valida;
    logic                r_sin_eco, w_sin_eco;
    logic                r_echo_m, r_echo_s, r_echo_d;
    logic                w_rise, w_fall;

    assign w_rise = r_echo_s & ~r_echo_d;
    assign w_fall = ~r_echo_s & r_echo_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ESPERA;
            r_cnt     <= '0;
            r_pre     <= '0;
            r_unit    <= '0;
            r_trig    <= 1'b0;
            r_dist    <= '0;
            r_valida  <= 1'b0;
            r_sin_eco <= 1'b0;
            r_echo_m  <= 1'b0;
            r_echo_s  <= 1'b0;
            r_echo_d  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_pre     <= w_pre;
            r_unit    <= w_unit;
            r_trig    <= w_trig;
            r_dist    <= w_dist;
            r_valida  <= w_valida;
            r_sin_eco <= w_sin_eco;
            r_echo_m  <= bus.echo;
            r_echo_s  <= r_echo_m;
            r_echo_d  <= r_echo_s;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_pre     = r_pre;
        w_unit    = r_unit;
        w_trig    = r_trig;
        w_dist    = r_dist;
        w_valida  = 1'b0;
        w_sin_eco = r_sin_eco;
        case (r_state)
            ESPERA: begin
                // With en low the pause count parks at its terminal value.
                if (r_cnt == CNT_W'(PAUSA - 1)) begin
                    if (bus.en) begin
                        w_cnt   = '0;
                        w_trig  = 1'b1;
                        w_state = DISPARO;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            DISPARO: begin
                if (r_cnt == CNT_W'(TRIG_CYCLES - 1)) begin
                    w_cnt   = '0;
                    w_trig  = 1'b0;
                    w_state = ESPERA_ECO;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ESPERA_ECO: begin
                if (w_rise) begin
                    w_cnt   = '0;
                    w_pre   = PRE_FIRST;
                    w_unit  = UNIT_FIRST;
                    w_state = MEDIR;
                end else if (r_cnt == CNT_W'(ECHO_TIMEOUT - 1)) begin
                    w_dist    = 9'(DIST_MAX);
                    w_sin_eco = 1'b1;
                    w_valida  = 1'b1;
                    w_state   = FIN;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            MEDIR: begin
                if (w_fall) begin
                    w_dist    = 9'(r_unit);
                    w_sin_eco = 1'b0;
                    w_valida  = 1'b1;
                    w_state   = FIN;
                end else if (r_cnt == CNT_W'(ECHO_TIMEOUT - 1)) begin
                    w_dist    = 9'(DIST_MAX);
                    w_sin_eco = 1'b1;
                    w_valida  = 1'b1;
                    w_state   = FIN;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                    if (r_echo_s) begin
                        if (r_pre == PRE_W'(CYC_PER_UNIT - 1)) begin
                            w_pre = '0;
                            if (r_unit != UNIT_W'(DIST_MAX))
                                w_unit = r_unit + 1'b1;
                        end else begin
                            w_pre = r_pre + 1'b1;
                        end
                    end
                end
            end
            FIN: begin
                w_cnt   = '0;
                w_state = ESPERA;
            end
            default: begin
                w_cnt   = '0;
                w_state = ESPERA;
            end
        endcase
    end

    assign bus.trig        = r_trig;
    assign bus.distancia   = r_dist;
    assign bus.dist_valida = r_valida;
    assign bus.sin_eco     = r_sin_eco;

endmodule
